avalon_pio_bank: RTL and testbench

AVALON_PIO_BANK -- requirements
Module: avalon_pio_bank

---
 rtl/avalon_pio_bank_if.sv | 12 +
 rtl/avalon_pio_bank.sv | 83 ++++++++
 tb/tb_avalon_pio_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_bank_if.sv
// Avalon-MM slave bus bundle for avalon_pio_bank: word address, select,
// active-low write strobe and 32-bit data in both directions.
interface avalon_pio_bank_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO output bank, shadow register committed to out_port on a frame_sync edge.
// Define PIO_BANK_DBUF_EN for double buffering; otherwise out_port follows every write.
module avalon_pio_bank #(
  parameter int          WIDTH       = 2,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  avalon_pio_bank_if.slave bus,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_SET = 2'd2, A_CLR = 2'd3;

  logic [WIDTH-1:0] shadow, active, shadow_nxt;
  logic             pending, commit_seen, irq_en, sync_q;
  logic             wr, wr_ctrl, fs_edge;
  logic [31:0]      rdata;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_ctrl = wr & (bus.address == A_CTRL);
  assign fs_edge = frame_sync & ~sync_q;

  always_comb begin
    shadow_nxt = shadow;
    if (wr) begin
      case (bus.address)
        A_DATA:  shadow_nxt = bus.writedata[WIDTH-1:0];
        A_SET:   shadow_nxt = shadow | bus.writedata[WIDTH-1:0];
        A_CLR:   shadow_nxt = shadow & ~bus.writedata[WIDTH-1:0];
        default: shadow_nxt = shadow;
      endcase
    end
  end

`ifdef PIO_BANK_DBUF_EN
  logic wr_shadow, commit;
  assign wr_shadow = wr & (bus.address != A_CTRL);
  assign commit    = (fs_edge & pending) | (wr_ctrl & bus.writedata[0]);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= RESET_VALUE[WIDTH-1:0];
      active      <= RESET_VALUE[WIDTH-1:0];
      pending     <= 1'b0;
      commit_seen <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      // high so a frame_sync already high at release is not taken as an edge
      sync_q      <= 1'b1;
    end else begin
      shadow <= shadow_nxt;
`ifdef PIO_BANK_DBUF_EN
      // commit takes the pre-write shadow; a same-cycle write re-arms pending
      if (commit) active <= shadow;
      if (wr_shadow)   pending <= 1'b1;
      else if (commit) pending <= 1'b0;
`else
      active  <= shadow_nxt;
      pending <= 1'b0;
`endif
      if (fs_edge)                            commit_seen <= 1'b1;
      else if (wr_ctrl && bus.writedata[1])   commit_seen <= 1'b0;
      if (wr_ctrl) irq_en <= bus.writedata[2];
      irq    <= commit_seen & irq_en;
      sync_q <= frame_sync;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      A_DATA:  rdata[WIDTH-1:0] = shadow;
      A_CTRL:  rdata[2:0]       = {irq_en, commit_seen, pending};
      default: rdata            = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = active;
endmodule

// File: tb/tb_avalon_pio_bank.sv
// Bench for avalon_pio_bank (WIDTH=8, RESET_VALUE=0x3C): directed scenarios with literal
// expectations, then random traffic checked every cycle against a register-map model.
module tb_avalon_pio_bank;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h3C;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_sync = 1'b0;
  logic [W-1:0] out_port;
  logic         irq;
  int           n_cmp = 0;
  int           n_bad = 0;

  avalon_pio_bank_if bus ();

  avalon_pio_bank #(.WIDTH(W), .RESET_VALUE(32'h3C)) dut (
    .clk(clk), .reset(reset), .bus(bus), .frame_sync(frame_sync),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // register-map model: state advanced once per rising edge from the sampled inputs
  logic [W-1:0] m_sh, m_act;
  logic         m_pend, m_seen, m_ien, m_irq, m_fs_prev, m_ok = 1'b0;

  always @(posedge clk) begin : model
    logic         w, ed;
    logic [W-1:0] nsh;
    logic [31:0]  d;
    if (reset) begin
      m_sh <= RV; m_act <= RV; m_pend <= 1'b0; m_seen <= 1'b0;
      m_ien <= 1'b0; m_irq <= 1'b0; m_fs_prev <= 1'b1; m_ok <= 1'b1;
    end else begin
      w   = bus.chipselect && !bus.write_n;
      d   = bus.writedata;
      ed  = frame_sync && !m_fs_prev;
      nsh = m_sh;
      if (w && bus.address == 2'd0) nsh = d[W-1:0];
      if (w && bus.address == 2'd2) nsh = m_sh | d[W-1:0];
      if (w && bus.address == 2'd3) nsh = m_sh & ~d[W-1:0];
`ifdef PIO_BANK_DBUF_EN
      if ((ed && m_pend) || (w && bus.address == 2'd1 && d[0])) begin
        m_act  <= m_sh;
        m_pend <= 1'b0;
      end
      if (w && bus.address != 2'd1) m_pend <= 1'b1;
`else
      m_act <= nsh;
`endif
      m_sh <= nsh;
      if (ed) m_seen <= 1'b1;
      else if (w && bus.address == 2'd1 && d[1]) m_seen <= 1'b0;
      if (w && bus.address == 2'd1) m_ien <= d[2];
      m_irq     <= m_seen && m_ien;
      m_fs_prev <= frame_sync;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 2'd0) r = {24'd0, m_sh};
    if (a == 2'd1) r = {29'd0, m_ien, m_seen, m_pend};
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      n_cmp++;
      if (out_port !== m_act || irq !== m_irq || bus.readdata !== m_read(bus.address)) begin
        n_bad++;
        $display("FAIL model t=%0t: out_port=%h irq=%b readdata=%h, expected %h %b %h",
                 $time, out_port, irq, bus.readdata, m_act, m_irq, m_read(bus.address));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    step(1);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(nm, bus.readdata, exp);
  endtask

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
    step(2);
    chk("reset_out", {24'd0, out_port}, 32'h3C);
    rd("reset_ctrl", 2'd1, 32'h0);
    reset = 1'b0;
    step(1);
`ifdef PIO_BANK_DBUF_EN
    wr(2'd0, 32'h0); wr(2'd1, 32'h1);
    chk("zero_out", {24'd0, out_port}, 32'h00);
    // DATA write is held back until frame_sync
    wr(2'd0, 32'hFFFF_FFA5);
    chk("hold_out", {24'd0, out_port}, 32'h00);
    rd("hold_ctrl", 2'd1, 32'h1);
    frame_sync = 1'b1; step(1); frame_sync = 1'b0;
    chk("fs_out", {24'd0, out_port}, 32'hA5);
    rd("fs_ctrl", 2'd1, 32'h2);
    // set/clear arithmetic and forced commit
    wr(2'd1, 32'h2); wr(2'd0, 32'h0F); wr(2'd2, 32'hF0); wr(2'd3, 32'h03);
    rd("setclr_data", 2'd0, 32'hFC);
    chk("setclr_out", {24'd0, out_port}, 32'hA5);
    wr(2'd1, 32'h1);
    chk("force_out", {24'd0, out_port}, 32'hFC);
    rd("force_ctrl", 2'd1, 32'h0);
    // write coinciding with commit
    wr(2'd0, 32'h22);
    frame_sync = 1'b1; wr(2'd0, 32'h11); frame_sync = 1'b0;
    chk("coll_out", {24'd0, out_port}, 32'h22);
    rd("coll_data", 2'd0, 32'h11);
    rd("coll_ctrl", 2'd1, 32'h3);
    // long frame_sync: single edge, irq two cycles after rise
    wr(2'd1, 32'h6); step(1);
    frame_sync = 1'b1; step(1);
    chk("long_irq0", {31'd0, irq}, 32'h0);
    chk("long_out", {24'd0, out_port}, 32'h11);
    rd("long_ctrl", 2'd1, 32'h6);
    step(1);
    chk("long_irq1", {31'd0, irq}, 32'h1);
    wr(2'd0, 32'h77); step(7);
    frame_sync = 1'b0; step(1);
    chk("long_nocommit", {24'd0, out_port}, 32'h11);
    rd("long_pend", 2'd1, 32'h7);
    wr(2'd1, 32'h6); step(1);
    chk("irq_clear", {31'd0, irq}, 32'h0);
    // reset mid-pending with frame_sync high at release
    frame_sync = 1'b1; reset = 1'b1; step(2);
    chk("rst_out", {24'd0, out_port}, 32'h3C);
    rd("rst_data", 2'd0, 32'h3C);
    reset = 1'b0; step(2);
    rd("rst_noedge", 2'd1, 32'h0);
    frame_sync = 1'b0; step(1);
    // set of commit_seen wins over a coincident clear
    frame_sync = 1'b1; wr(2'd1, 32'h2); frame_sync = 1'b0;
    rd("set_wins", 2'd1, 32'h2);
`else
    wr(2'd0, 32'h55);
    chk("direct_out", {24'd0, out_port}, 32'h55);
    rd("direct_ctrl", 2'd1, 32'h0);
    wr(2'd2, 32'h0A); wr(2'd3, 32'h05);
    chk("direct_setclr", {24'd0, out_port}, 32'h5A);
    wr(2'd1, 32'h1);
    chk("ctrl0_noeffect", {24'd0, out_port}, 32'h5A);
    rd("ctrl0_ctrl", 2'd1, 32'h0);
    frame_sync = 1'b1; step(1); frame_sync = 1'b0;
    rd("direct_seen", 2'd1, 32'h2);
    wr(2'd1, 32'h4);
    chk("direct_irq0", {31'd0, irq}, 32'h0);
    step(1);
    chk("direct_irq1", {31'd0, irq}, 32'h1);
    wr(2'd1, 32'h6); step(1);
    chk("direct_irq_clr", {31'd0, irq}, 32'h0);
    rd("direct_ctrl_end", 2'd1, 32'h4);
`endif
    // random traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      reset            = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) frame_sync = ~frame_sync;
      bus.chipselect   = $urandom_range(0, 1) == 1;
      bus.write_n      = $urandom_range(0, 1) == 1;
      bus.address      = 2'($urandom_range(0, 3));
      bus.writedata    = $urandom;
      step(1);
    end
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
